// File: rtl/clkbuf_activity_monitor_pkg.sv
// Shared types and constants for the clock-buffer activity monitor.
// Imported by the top level; the synchronizer sub-module is kept package-free for reuse.
package clkbuf_activity_monitor_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } mon_state_e;

  // Cycles spent in ARM so that stale synchronizer contents never reach the edge counter.
  localparam int ARM_CYCLES = 3;

  // Bits needed to hold the values 0 .. value-1 (never less than one bit).
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/clkmon_sync_edge.sv
// Two-flop synchronizer followed by a third flop for rising-edge detection of an
// input that is asynchronous to clk_i.
module clkmon_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic edge_o
);

  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;

  assign s1_d = async_i;
  assign s2_d = s1_q;
  assign s3_d = s2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign edge_o = s2_q & ~s3_q;

endmodule

// File: rtl/clkbuf_activity_monitor.sv
// Clock-buffer activity monitor: counts synchronized MON rising edges per CLK window
// and flags fast, slow and lost conditions on the buffered clock.
module clkbuf_activity_monitor
  import clkbuf_activity_monitor_pkg::*;
#(
  parameter int WIN_LEN   = 256,
  parameter int CNT_W     = 9,
  parameter int MIN_EDGES = 60,
  parameter int MAX_EDGES = 68,
  parameter int LOSS_TO   = 16
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             MON,
  input  logic             EN,
  output logic [CNT_W-1:0] COUNT,
  output logic             VALID,
  output logic             FAST,
  output logic             SLOW,
  output logic             LOST,
  inout  wire              VDD,
  inout  wire              VSS
);

  localparam int WIN_W = clog2(WIN_LEN);
  localparam int TO_W  = clog2(LOSS_TO + 1);
  localparam int ARM_W = clog2(ARM_CYCLES);

  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);
  localparam logic [TO_W-1:0]  TO_MAX   = TO_W'(LOSS_TO);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ARM_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  if (MIN_EDGES > MAX_EDGES) begin : g_bad_thresholds
    $error("clkbuf_activity_monitor: MIN_EDGES must not exceed MAX_EDGES");
  end
  if (WIN_LEN < 8) begin : g_bad_window
    $error("clkbuf_activity_monitor: WIN_LEN must be at least 8");
  end
  if (LOSS_TO < 1) begin : g_bad_timeout
    $error("clkbuf_activity_monitor: LOSS_TO must be at least 1");
  end

  // Supplies are present for netlist compatibility only.
  wire unused_supply;
  assign unused_supply = VDD ^ VSS;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                               input logic             inc);
    if (inc && (cnt != CNT_MAX)) return cnt + CNT_W'(1);
    return cnt;
  endfunction

  function automatic logic [TO_W-1:0] sat_tick(input logic [TO_W-1:0] cnt);
    if (cnt != TO_MAX) return cnt + TO_W'(1);
    return cnt;
  endfunction

  mon_state_e       state_q, state_d;
  logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             fast_q, fast_d;
  logic             slow_q, slow_d;
  logic             valid_q, valid_d;

  logic             edge_det;
  logic [CNT_W-1:0] closing_cnt;
  logic             above_max;
  logic             below_min;

  // MON crosses into the CLK domain here; edge_det lags a MON rise by two CLK edges.
  clkmon_sync_edge u_sync_edge (
    .clk_i   (CLK),
    .rst_ni  (RN),
    .async_i (MON),
    .edge_o  (edge_det)
  );

  // The final window cycle's edge belongs to the closing window.
  assign closing_cnt = sat_add(edge_cnt_q, edge_det);
  assign above_max   = int'(closing_cnt) > MAX_EDGES;
  assign below_min   = int'(closing_cnt) < MIN_EDGES;

  always_comb begin
    state_d    = state_q;
    arm_cnt_d  = arm_cnt_q;
    win_cnt_d  = win_cnt_q;
    edge_cnt_d = edge_cnt_q;
    to_cnt_d   = to_cnt_q;
    count_d    = count_q;
    fast_d     = fast_q;
    slow_d     = slow_q;
    valid_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        arm_cnt_d  = '0;
        win_cnt_d  = '0;
        edge_cnt_d = '0;
        to_cnt_d   = '0;
        if (EN) state_d = ARM;
      end

      ARM: begin
        win_cnt_d  = '0;
        edge_cnt_d = '0;
        to_cnt_d   = '0;
        if (!EN) begin
          state_d   = IDLE;
          arm_cnt_d = '0;
        end else if (arm_cnt_q == ARM_LAST) begin
          state_d   = MEASURE;
          arm_cnt_d = '0;
        end else begin
          arm_cnt_d = arm_cnt_q + ARM_W'(1);
        end
      end

      MEASURE: begin
        if (!EN) begin
          // Abort discards the partial window; published results stay untouched.
          state_d    = IDLE;
          win_cnt_d  = '0;
          edge_cnt_d = '0;
          to_cnt_d   = '0;
        end else begin
          to_cnt_d = edge_det ? '0 : sat_tick(to_cnt_q);
          if (win_cnt_q == WIN_LAST) begin
            count_d    = closing_cnt;
            fast_d     = above_max;
            slow_d     = below_min;
            valid_d    = 1'b1;
            win_cnt_d  = '0;
            edge_cnt_d = '0;
          end else begin
            win_cnt_d  = win_cnt_q + WIN_W'(1);
            edge_cnt_d = closing_cnt;
          end
        end
      end

      default: begin
        state_d    = IDLE;
        arm_cnt_d  = '0;
        win_cnt_d  = '0;
        edge_cnt_d = '0;
        to_cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q    <= IDLE;
      arm_cnt_q  <= '0;
      win_cnt_q  <= '0;
      edge_cnt_q <= '0;
      to_cnt_q   <= '0;
      count_q    <= '0;
      fast_q     <= 1'b0;
      slow_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      arm_cnt_q  <= arm_cnt_d;
      win_cnt_q  <= win_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      to_cnt_q   <= to_cnt_d;
      count_q    <= count_d;
      fast_q     <= fast_d;
      slow_q     <= slow_d;
      valid_q    <= valid_d;
    end
  end

  // The timeout counter is only non-zero in MEASURE, so LOST needs no state qualifier.
  assign COUNT = count_q;
  assign VALID = valid_q;
  assign FAST  = fast_q;
  assign SLOW  = slow_q;
  assign LOST  = (to_cnt_q == TO_MAX);

endmodule

// File: tb/tb_clkbuf_activity_monitor.sv
// Scoreboard bench for clkbuf_activity_monitor: default instance plus a narrow-counter
// instance that exercises saturation.
module tb_clkbuf_activity_monitor;

  localparam int WIN = 256;

  typedef struct {
    bit         care;
    logic [8:0] count;
    logic       fast;
    logic       slow;
    bit         lost_care;
    logic       lost;
    int         due;
  } exp_t;

  logic       clk, rn, mon, en, mon2, en2;
  wire        vdd = 1'b1;
  wire        vss = 1'b0;
  logic [8:0] count;
  logic       valid, fast, slow, lost;
  logic [4:0] count2;
  logic       valid2, fast2, slow2, lost2;

  int  cyc, n_cmp, n_fail, valid_seen, last_valid_cyc, last_rise;
  int  mon_div, mon_ph, ph3;
  bit  mon_run;
  exp_t sb[$];
  exp_t sb2[$];

  clkbuf_activity_monitor dut (
    .CLK(clk), .RN(rn), .MON(mon), .EN(en), .COUNT(count), .VALID(valid),
    .FAST(fast), .SLOW(slow), .LOST(lost), .VDD(vdd), .VSS(vss)
  );

  clkbuf_activity_monitor #(
    .WIN_LEN(256), .CNT_W(5), .MIN_EDGES(20), .MAX_EDGES(28), .LOSS_TO(16)
  ) dut_sat (
    .CLK(clk), .RN(rn), .MON(mon2), .EN(en2), .COUNT(count2), .VALID(valid2),
    .FAST(fast2), .SLOW(slow2), .LOST(lost2), .VDD(vdd), .VSS(vss)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // MON generators: driven 2 time units after the active edge.
  initial begin
    logic nv;
    forever begin
      @(posedge clk);
      #2;
      if (mon_run) begin
        mon_ph = (mon_ph + 1) % mon_div;
        nv = (mon_ph < mon_div / 2);
        if (nv && !mon) last_rise = cyc;
        mon = nv;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      ph3 = (ph3 + 1) % 3;
      mon2 = (ph3 == 0);
    end
  end

  // Scoreboard monitor for the default instance.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rn && valid) begin
        valid_seen++;
        if (sb.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL sb_unexpected_valid: VALID=1 at cycle %0d, no window expected", cyc);
        end else begin
          e = sb.pop_front();
          last_valid_cyc = cyc;
          if (e.due >= 0) begin
            n_cmp++;
            if (cyc !== e.due) begin
              n_fail++;
              $display("FAIL sb_valid_cycle: got cycle %0d expected %0d", cyc, e.due);
            end
          end
          if (e.care) begin
            n_cmp++;
            if (count !== e.count) begin
              n_fail++;
              $display("FAIL sb_count: got %0d expected %0d (cycle %0d)", count, e.count, cyc);
            end
            n_cmp++;
            if (fast !== e.fast) begin
              n_fail++;
              $display("FAIL sb_fast: got %b expected %b (cycle %0d)", fast, e.fast, cyc);
            end
            n_cmp++;
            if (slow !== e.slow) begin
              n_fail++;
              $display("FAIL sb_slow: got %b expected %b (cycle %0d)", slow, e.slow, cyc);
            end
          end
          if (e.lost_care) begin
            n_cmp++;
            if (lost !== e.lost) begin
              n_fail++;
              $display("FAIL sb_lost: got %b expected %b (cycle %0d)", lost, e.lost, cyc);
            end
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(input bit care, input int c, input logic f, input logic s,
                              input bit lc, input logic l, input int due);
    exp_t e;
    e.care = care; e.count = 9'(c); e.fast = f; e.slow = s;
    e.lost_care = lc; e.lost = l; e.due = due;
    return e;
  endfunction

  task automatic drain(input int budget, output bit expired);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    expired = (sb.size() != 0);
    if (expired) sb.delete();
  endtask

  task automatic test_reset;
    rn = 1'b0; en = 1'b0; en2 = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (count !== 9'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
    n_cmp++; if ({fast, slow, lost} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {fast, slow, lost}); end
    n_cmp++; if ({count2, fast2, slow2, lost2} !== 8'd0) begin n_fail++; $display("FAIL reset_sat_outputs: got %h expected 0", {count2, fast2, slow2, lost2}); end
    rn = 1'b1;
    repeat (20) @(negedge clk);
    n_cmp++; if (valid_seen !== 0) begin n_fail++; $display("FAIL idle_no_valid: got %0d pulses expected 0", valid_seen); end
  endtask

  task automatic test_nominal;
    bit expired;
    int c;
    c = cyc;
    en = 1'b1;
    for (int i = 0; i < 3; i++) sb.push_back(mk(1, 64, 0, 0, 1, 0, c + 260 + WIN * i));
    drain(3 * WIN + 80, expired);
    n_cmp++; if (expired !== 1'b0) begin n_fail++; $display("FAIL nominal_timeout: windows outstanding got 1 expected 0"); end
  endtask

  task automatic test_slow;
    bit expired;
    int v;
    v = last_valid_cyc;
    mon_div = 8; mon_ph = 0;
    sb.push_back(mk(0, 0, 0, 0, 0, 0, v + WIN));
    sb.push_back(mk(1, 32, 0, 1, 1, 0, v + 2 * WIN));
    drain(2 * WIN + 20, expired);
    n_cmp++; if (expired !== 1'b0) begin n_fail++; $display("FAIL slow_timeout: windows outstanding got 1 expected 0"); end
    v = last_valid_cyc;
    mon_div = 4; mon_ph = 0;
    sb.push_back(mk(0, 0, 0, 0, 0, 0, v + WIN));
    sb.push_back(mk(1, 64, 0, 0, 1, 0, v + 2 * WIN));
    drain(2 * WIN + 20, expired);
    n_cmp++; if (expired !== 1'b0) begin n_fail++; $display("FAIL slow_recover_timeout: windows outstanding got 1 expected 0"); end
  endtask

  task automatic test_loss;
    bit expired;
    int v, r, s;
    v = last_valid_cyc;
    mon_run = 1'b0;
    @(negedge clk);
    mon = 1'b0;
    r = last_rise;
    while (cyc < r + 18) @(negedge clk);
    n_cmp++; if (lost !== 1'b0) begin n_fail++; $display("FAIL loss_early: got %b expected 0 at rise+18", lost); end
    @(negedge clk);
    n_cmp++; if (lost !== 1'b1) begin n_fail++; $display("FAIL loss_raise: got %b expected 1 at rise+19", lost); end
    while (cyc < r + 40) @(negedge clk);
    n_cmp++; if (lost !== 1'b1) begin n_fail++; $display("FAIL loss_hold: got %b expected 1", lost); end
    s = cyc;
    mon = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (lost !== 1'b1) begin n_fail++; $display("FAIL loss_clear_early: got %b expected 1 at restart+2 (start %0d)", lost, s); end
    @(negedge clk);
    n_cmp++; if (lost !== 1'b0) begin n_fail++; $display("FAIL loss_clear: got %b expected 0 at restart+3", lost); end
    mon_div = 4; mon_ph = 0; mon_run = 1'b1;
    sb.push_back(mk(0, 0, 0, 0, 1, 0, v + WIN));
    sb.push_back(mk(1, 64, 0, 0, 1, 0, v + 2 * WIN));
    drain(2 * WIN + 20, expired);
    n_cmp++; if (expired !== 1'b0) begin n_fail++; $display("FAIL loss_timeout: windows outstanding got 1 expected 0"); end
  endtask

  task automatic test_boundary;
    bit expired;
    int v2, v3, c;
    v2 = last_valid_cyc + WIN;
    v3 = v2 + WIN;
    mon_run = 1'b0;
    sb.push_back(mk(0, 0, 0, 0, 0, 0, v2));
    sb.push_back(mk(1, 64, 0, 0, 1, 0, v3));
    sb.push_back(mk(1, 0, 0, 1, 1, 1, v3 + WIN));
    // Rises every 4 cycles, the last one detected on the final cycle of window v2.
    while (cyc <= v3 + 1) begin
      c = cyc;
      mon = (c >= v2 + 1) && (c <= v2 + 254) && (((c - v2 - 1) % 4) < 2);
      @(negedge clk);
    end
    drain(2 * WIN, expired);
    n_cmp++; if (expired !== 1'b0) begin n_fail++; $display("FAIL boundary_timeout: windows outstanding got 1 expected 0"); end
    c = last_valid_cyc;
    mon_div = 4; mon_ph = 0; mon_run = 1'b1;
    sb.push_back(mk(0, 0, 0, 0, 0, 0, c + WIN));
    sb.push_back(mk(1, 64, 0, 0, 1, 0, c + 2 * WIN));
    drain(2 * WIN + 20, expired);
    n_cmp++; if (expired !== 1'b0) begin n_fail++; $display("FAIL boundary_recover_timeout: windows outstanding got 1 expected 0"); end
  endtask

  task automatic test_abort;
    int v, vs;
    v = last_valid_cyc;
    while (cyc < v + 100) @(negedge clk);
    en = 1'b0;
    vs = valid_seen;
    repeat (300) @(negedge clk);
    n_cmp++; if (valid_seen !== vs) begin n_fail++; $display("FAIL abort_no_valid: got %0d pulses expected 0", valid_seen - vs); end
    n_cmp++; if (count !== 9'd64) begin n_fail++; $display("FAIL abort_count_held: got %0d expected 64", count); end
    n_cmp++; if ({fast, slow} !== 2'b00) begin n_fail++; $display("FAIL abort_flags_held: got %b expected 00", {fast, slow}); end
    n_cmp++; if (lost !== 1'b0) begin n_fail++; $display("FAIL abort_lost: got %b expected 0", lost); end
  endtask

  task automatic test_fast_saturation;
    exp_t e;
    int c, n;
    c = cyc;
    en2 = 1'b1;
    sb2.push_back(mk(1, 31, 1, 0, 1, 0, c + 260));
    sb2.push_back(mk(1, 31, 1, 0, 1, 0, c + 260 + WIN));
    n = 0;
    while (sb2.size() != 0 && n < 600) begin
      @(negedge clk);
      n++;
      if (valid2) begin
        e = sb2.pop_front();
        n_cmp++; if (cyc !== e.due) begin n_fail++; $display("FAIL sat_valid_cycle: got %0d expected %0d", cyc, e.due); end
        n_cmp++; if ({4'd0, count2} !== e.count) begin n_fail++; $display("FAIL sat_count: got %0d expected %0d", count2, e.count); end
        n_cmp++; if (fast2 !== e.fast) begin n_fail++; $display("FAIL sat_fast: got %b expected %b", fast2, e.fast); end
        n_cmp++; if (slow2 !== e.slow) begin n_fail++; $display("FAIL sat_slow: got %b expected %b", slow2, e.slow); end
        n_cmp++; if (lost2 !== e.lost) begin n_fail++; $display("FAIL sat_lost: got %b expected %b", lost2, e.lost); end
      end
    end
    n_cmp++; if (sb2.size() !== 0) begin n_fail++; $display("FAIL sat_timeout: windows outstanding got %0d expected 0", sb2.size()); end
    sb2.delete();
    en2 = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++; if ({count2, fast2} !== {5'd31, 1'b1}) begin n_fail++; $display("FAIL sat_held: got %0d/%b expected 31/1", count2, fast2); end
  endtask

  task automatic test_reset_mid_window;
    bit expired;
    int c;
    en = 1'b1;
    repeat (150) @(negedge clk);
    #2;
    rn = 1'b0;
    #1;
    n_cmp++; if (count !== 9'd0) begin n_fail++; $display("FAIL rst_async_count: got %0d expected 0", count); end
    n_cmp++; if ({valid, fast, slow, lost} !== 4'b0000) begin n_fail++; $display("FAIL rst_async_flags: got %b expected 0000", {valid, fast, slow, lost}); end
    n_cmp++; if ({count2, fast2} !== 6'd0) begin n_fail++; $display("FAIL rst_async_sat: got %0d/%b expected 0/0", count2, fast2); end
    en = 1'b0;
    @(negedge clk);
    rn = 1'b1;
    @(negedge clk);
    c = cyc;
    en = 1'b1;
    sb.push_back(mk(1, 64, 0, 0, 1, 0, c + 260));
    drain(WIN + 80, expired);
    n_cmp++; if (expired !== 1'b0) begin n_fail++; $display("FAIL rst_first_window_timeout: windows outstanding got 1 expected 0"); end
    en = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; valid_seen = 0; last_valid_cyc = 0; last_rise = 0;
    mon = 1'b0; mon2 = 1'b0; ph3 = 0;
    mon_div = 4; mon_ph = 0; mon_run = 1'b1;
    rn = 1'b0; en = 1'b0; en2 = 1'b0;
    @(negedge clk);
    test_reset();
    test_nominal();
    test_slow();
    test_loss();
    test_boundary();
    test_abort();
    test_fast_saturation();
    test_reset_mid_window();
    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
